bitwise_nand_gate: RTL and testbench



---
 rtl/bitwise_nand_pkg.sv | 14 +
 rtl/bitwise_nand_core.sv | 20 ++
 rtl/bitwise_nand_gate.sv | 87 ++++++++
 tb/tb_bitwise_nand_gate.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_nand_pkg.sv
// Shared constants and helpers for the bitwise NAND primitive.
// The library-width NAND function is here for callers that stay at the default width.
package bitwise_nand_pkg;

   localparam int DEFAULT_WIDTH = 32;

   function automatic logic [DEFAULT_WIDTH-1:0] nand_vec(
      input logic [DEFAULT_WIDTH-1:0] a,
      input logic [DEFAULT_WIDTH-1:0] b
   );
      return ~(a & b);
   endfunction

endpackage

// File: rtl/bitwise_nand_core.sv
// Combinational WIDTH-bit NAND with result status flags.
// This module holds no state; the top level decides whether the result is registered.
module bitwise_nand_core
   import bitwise_nand_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y,
   output logic             all_ones,
   output logic             zero
);

   // Each result bit depends only on the matching operand bits.
   assign y        = ~(a & b);
   assign all_ones = &y;
   assign zero     = ~|y;

endmodule

// File: rtl/bitwise_nand_gate.sv
// Valid-qualified bitwise NAND stage with all-ones / zero flags.
// OUT_REG selects a one-cycle registered result or a purely combinational pass-through.
module bitwise_nand_gate
   import bitwise_nand_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter bit OUT_REG = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   output logic [WIDTH-1:0] out,
   output logic             out_all_ones,
   output logic             out_zero
);

   logic [WIDTH-1:0] core_y;
   logic             core_all_ones;
   logic             core_zero;

   bitwise_nand_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a        (in1),
      .b        (in2),
      .y        (core_y),
      .all_ones (core_all_ones),
      .zero     (core_zero)
   );

   if (OUT_REG) begin : g_reg

      logic [WIDTH-1:0] out_q, out_d;
      logic             all_ones_q, all_ones_d;
      logic             zero_q, zero_d;
      logic             valid_q;

      always_comb begin
         // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
         out_d      = out_q;
         all_ones_d = all_ones_q;
         zero_d     = zero_q;
         // Loading only on in_valid keeps garbage on idle inputs out of the held result.
         if (in_valid) begin
            out_d      = core_y;
            all_ones_d = core_all_ones;
            zero_d     = core_zero;
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         if (!rst_n) begin
            out_q      <= '0;
            all_ones_q <= 1'b0;
            zero_q     <= 1'b0;
            valid_q    <= 1'b0;
         end else begin
            out_q      <= out_d;
            all_ones_q <= all_ones_d;
            zero_q     <= zero_d;
            valid_q    <= in_valid;
         end
      end

      assign out          = out_q;
      assign out_all_ones = all_ones_q;
      assign out_zero     = zero_q;
      assign out_valid    = valid_q;

   end else begin : g_comb

      // Clock and reset have no role in the pass-through configuration.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign out          = core_y;
      assign out_all_ones = core_all_ones;
      assign out_zero     = core_zero;
      assign out_valid    = in_valid;

   end

endmodule

// File: tb/tb_bitwise_nand_gate.sv
// Self-checking bench: registered 32-bit instance with a result scoreboard,
// plus a 1-bit combinational instance swept over its full truth table.
module tb_bitwise_nand_gate;

   typedef struct packed {
      logic [31:0] y;
      logic        all_ones;
      logic        zero;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in1, in2;
   logic        out_valid;
   logic [31:0] out;
   logic        out_all_ones, out_zero;

   logic        c_valid, c_in1, c_in2;
   logic        c_out_valid, c_out, c_all_ones, c_zero;

   exp_t        sb[$];
   exp_t        want;
   exp_t        got;
   int          n_cmp = 0;
   int          n_bad = 0;

   bitwise_nand_gate #(.WIDTH(32), .OUT_REG(1'b1)) dut_reg (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in1          (in1),
      .in2          (in2),
      .out_valid    (out_valid),
      .out          (out),
      .out_all_ones (out_all_ones),
      .out_zero     (out_zero)
   );

   bitwise_nand_gate #(.WIDTH(1), .OUT_REG(1'b0)) dut_comb (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (c_valid),
      .in1          (c_in1),
      .in2          (c_in2),
      .out_valid    (c_out_valid),
      .out          (c_out),
      .out_all_ones (c_all_ones),
      .out_zero     (c_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
      $fatal(1);
   end

   // Expected value built from the operand AND rather than from a NAND expression.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      logic [31:0] conj;
      conj       = a & b;
      e.y        = 32'hFFFF_FFFF ^ conj;
      e.all_ones = (conj == 32'h0);
      e.zero     = (conj == 32'hFFFF_FFFF);
      return e;
   endfunction

   task automatic drive_vec(input logic [31:0] a, input logic [31:0] b, input logic v);
      in1      = a;
      in2      = b;
      in_valid = v;
      if (v) sb.push_back(model(a, b));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_vec(32'h0, 32'h0, 1'b1);
      sb.delete();
      repeat (3) tick();
      got = {out, out_all_ones, out_zero};
      n_cmp++;
      if (got !== 34'h0) begin
         n_bad++;
         $display("FAIL reset_out: got %h want %h", got, 34'h0);
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_valid: got %b want 0", out_valid);
      end
      rst_n = 1'b1;
      drive_vec(32'h0, 32'h0, 1'b0);
      tick();
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL post_reset_idle_valid: got %b want 0", out_valid);
      end
   endtask

   task automatic test_directed();
      logic [31:0] a_tab[3] = '{32'h0000_0000, 32'h0000_001F, 32'h0000_000A};
      logic [31:0] b_tab[3] = '{32'h0000_0000, 32'h0000_001F, 32'h0000_0006};
      exp_t        e_tab[3] = '{{32'hFFFF_FFFF, 1'b1, 1'b0},
                                {32'hFFFF_FFE0, 1'b0, 1'b0},
                                {32'hFFFF_FFFD, 1'b0, 1'b0}};
      for (int i = 0; i < 3; i++) begin
         drive_vec(a_tab[i], b_tab[i], 1'b1);
         tick();
         n_cmp++;
         if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL directed_valid[%0d]: got %b want 1", i, out_valid);
         end
         want = (sb.size() != 0) ? sb.pop_front() : '0;
         got  = {out, out_all_ones, out_zero};
         n_cmp++;
         if (got !== want || want !== e_tab[i]) begin
            n_bad++;
            $display("FAIL directed_out[%0d]: got %h want %h", i, got, e_tab[i]);
         end
      end
      // Idle inputs, including unknowns, must not disturb the held result.
      drive_vec('x, 'x, 1'b0);
      tick();
      tick();
      got = {out, out_all_ones, out_zero};
      n_cmp++;
      if (got !== {32'hFFFF_FFFD, 1'b0, 1'b0}) begin
         n_bad++;
         $display("FAIL hold_out: got %h want %h", got, {32'hFFFF_FFFD, 1'b0, 1'b0});
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL hold_valid: got %b want 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 12; i++) begin
         drive_vec(32'($urandom_range(0, 31)), 32'($urandom_range(0, 31)), 1'b1);
         tick();
         n_cmp++;
         if (out_valid !== 1'b1 || sb.size() == 0) begin
            n_bad++;
            $display("FAIL b2b_valid[%0d]: got valid %b queued %0d want valid 1 queued 1",
                     i, out_valid, sb.size());
         end else begin
            want = sb.pop_front();
            got  = {out, out_all_ones, out_zero};
            n_cmp++;
            if (got !== want) begin
               n_bad++;
               $display("FAIL b2b_out[%0d]: got %h want %h", i, got, want);
            end
         end
      end
      drive_vec(32'h0, 32'h0, 1'b0);
      tick();
   endtask

   task automatic test_async_reset();
      drive_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      tick();
      want = (sb.size() != 0) ? sb.pop_front() : '1;
      got  = {out, out_all_ones, out_zero};
      n_cmp++;
      if (got !== want || out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL ones_in: got %h valid %b want %h valid 1", got, out_valid, want);
      end
      // Next result is in flight when reset hits between clock edges.
      drive_vec(32'h3, 32'h5, 1'b1);
      #3 rst_n = 1'b0;
      #1;
      got = {out, out_all_ones, out_zero};
      n_cmp++;
      if (got !== 34'h0 || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL async_clear: got %h valid %b want 0 valid 0", got, out_valid);
      end
      sb.delete();
      tick();
      tick();
      rst_n = 1'b1;
      drive_vec(32'h3, 32'h5, 1'b0);
      tick();
      n_cmp++;
      if (out_valid !== 1'b0 || out !== 32'h0) begin
         n_bad++;
         $display("FAIL after_release: got out %h valid %b want out 0 valid 0", out, out_valid);
      end
      drive_vec(32'h3, 32'h5, 1'b1);
      tick();
      want = (sb.size() != 0) ? sb.pop_front() : '0;
      got  = {out, out_all_ones, out_zero};
      n_cmp++;
      if (out_valid !== 1'b1 || got !== {32'hFFFF_FFFE, 1'b0, 1'b0} || got !== want) begin
         n_bad++;
         $display("FAIL first_after_reset: got %h valid %b want %h valid 1",
                  got, out_valid, {32'hFFFF_FFFE, 1'b0, 1'b0});
      end
   endtask

   task automatic test_comb_sweep();
      logic [1:0] pair;
      logic       exp_y;
      for (int i = 0; i < 4; i++) begin
         pair    = 2'(i);
         c_in1   = pair[1];
         c_in2   = pair[0];
         c_valid = pair[0] ^ pair[1];
         exp_y   = (i == 3) ? 1'b0 : 1'b1;
         #1;
         n_cmp++;
         if ({c_out, c_all_ones, c_zero, c_out_valid} !== {exp_y, exp_y, ~exp_y, c_valid}) begin
            n_bad++;
            $display("FAIL comb[%0d]: got %b want %b", i,
                     {c_out, c_all_ones, c_zero, c_out_valid}, {exp_y, exp_y, ~exp_y, c_valid});
         end
         #4;
      end
   endtask

   initial begin
      c_valid = 1'b0;
      c_in1   = 1'b0;
      c_in2   = 1'b0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_async_reset();
      test_comb_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
